fifo_stream_reader: RTL

- Read-side consumer for the team's sync FIFO (push/pop, registered rd_data).
- Drives the FIFO pop and captures rd_data one cycle after each pop.
- Re-presents the words on a valid/ready stream output with full throughput.
- Sits between a FIFO instance and any downstream valid/ready sink (serializer, bus master).

---
 rtl/fifo_rd_pkg.sv | 22 ++
 rtl/fifo_rd_stats.sv | 27 ++
 rtl/fifo_stream_reader.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    RD_EMPTY,
    RD_ONE,
    RD_TWO
  } rd_state_t;

  localparam int BUF_DEPTH = 2;
  localparam int STAT_W    = 16;

  // Number of words held in the skid buffer for a given state.
  function automatic logic [1:0] occ_of(input rd_state_t s);
    case (s)
      RD_ONE:  return 2'd1;
      RD_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_rd_stats.sv
// Saturating transfer and stall counters for fifo_stream_reader
// (present only when FIFO_RD_STATS_EN is defined).
module fifo_rd_stats
  import fifo_rd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              xfer,
  input  logic              stall,
  output logic [STAT_W-1:0] stat_words,
  output logic [STAT_W-1:0] stat_stalls
);

  // Counters stick at all-ones; flush deliberately does not clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else begin
      if (xfer && (stat_words != '1))
        stat_words <= stat_words + STAT_W'(1);
      if (stall && (stat_stalls != '1))
        stat_stalls <= stat_stalls + STAT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a registered-output sync FIFO and re-presents its words on a valid/ready
// stream through a 2-entry skid buffer. Optional counters: FIFO_RD_STATS_EN.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_words,
  output logic [STAT_W-1:0] stat_stalls
`endif
);

  rd_state_t        state, state_n;
  logic [WIDTH-1:0] head, head_n;
  logic [WIDTH-1:0] tail, tail_n;
  logic             inflight;
  logic             xfer;
  logic             cap;
  logic [2:0]       pending;

  assign out_valid = (state != RD_EMPTY);
  assign out_data  = head;
  assign xfer      = out_valid && out_ready;
  assign cap       = inflight && !flush;

  // Words that will occupy the buffer after this cycle if nothing new is popped.
  // The out_ready -> fifo_pop path is what sustains one word per cycle.
  assign pending  = 3'(occ_of(state)) + 3'(inflight) - 3'(xfer);
  assign fifo_pop = !rst && !fifo_empty && !flush && (pending < 3'(BUF_DEPTH));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  // NOTE: head/tail are reset too, because head drives out_data directly and
  // must read as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RD_EMPTY;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_n;
      head     <= head_n;
      tail     <= tail_n;
      inflight <= fifo_pop;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    head_n  = head;
    tail_n  = tail;
    if (flush) begin
      state_n = RD_EMPTY;
    end else begin
      case (state)
        RD_EMPTY: begin
          if (cap) begin
            state_n = RD_ONE;
            head_n  = fifo_rd_data;
          end
        end
        RD_ONE: begin
          if (cap && !xfer) begin
            state_n = RD_TWO;
            tail_n  = fifo_rd_data;
          end else if (cap && xfer) begin
            head_n = fifo_rd_data;
          end else if (xfer) begin
            state_n = RD_EMPTY;
          end
        end
        RD_TWO: begin
          // A capture without a transfer cannot happen here: the pop rule
          // withholds the pop that would have produced it.
          if (xfer) begin
            head_n = tail;
            if (cap) tail_n = fifo_rd_data;
            else     state_n = RD_ONE;
          end
        end
        default: state_n = RD_EMPTY;
      endcase
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic stall;
  assign stall = out_valid && !out_ready;

  fifo_rd_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .xfer        (xfer),
    .stall       (stall),
    .stat_words  (stat_words),
    .stat_stalls (stat_stalls)
  );
`endif

endmodule
